detect_event_counter: RTL and testbench
=======================================

DETECT_EVENT_COUNTER -- requirements
Module: detect_event_counter

Interface
REQ-001 Parameter: SEG_ACTIVE_LOW, default 1, selects 7-segment polarity; 1 means a lit segment is driven 0.
REQ-002 Port: SW[0]  input  1  clock; all state SHALL update on the rising edge only.
REQ-003 Port: SW[1]  input  1  reset; synchronous, active-high, sampled on the rising edge of SW[0].
REQ-004 Port: SW[2]  input  1  match level from the upstream 1011 sequence detector's LEDR[0].
REQ-005 Port: SW[3]  input  1  count enable; 1 = count, 0 = hold.
REQ-006 Port: SW[4]  input  1  limit mode; 0 = wrap 99->00, 1 = saturate at 99.
REQ-007 Port: LEDR  output  2  LEDR[0] = one-cycle event pulse; LEDR[1] = sticky limit flag.
REQ-008 Port: HEX0  output  7  ones digit, segment order gfedcba (bit 6 = g).
REQ-009 Port: HEX1  output  7  tens digit, same encoding as HEX0.

Function
REQ-010 The block SHALL hold a registered copy match_q of SW[2], updated every clock edge.
REQ-011 Event SHALL be defined as SW[2]=1 AND match_q=0 AND SW[3]=1, evaluated on the current edge.
REQ-012 A match level held high for N cycles SHALL produce exactly one event.
REQ-013 match_q SHALL track SW[2] while SW[3]=0: an edge occurring while disabled is never counted later.
REQ-014 A match already high when SW[3] rises SHALL NOT be counted.
REQ-015 Count SHALL be two BCD digits (ones[3:0], tens[3:0]), range 00-99.
REQ-016 On an event with count < 99: ones SHALL increment; if ones = 9, ones -> 0 and tens increments.
REQ-017 Count update latency SHALL be 1 cycle: the new value is visible on HEX0/HEX1 after the edge that detected the event.
REQ-018 On an event at count 99 with SW[4]=0, count SHALL become 00 and LEDR[1] SHALL set.
REQ-019 On an event at count 99 with SW[4]=1, count SHALL stay 99 and LEDR[1] SHALL set.
REQ-020 LEDR[1] SHALL remain set until reset; further events SHALL NOT clear it.
REQ-021 Changing SW[4] mid-operation SHALL take effect on the next event only; it SHALL NOT alter the current count.
REQ-022 LEDR[0] SHALL be registered: high for exactly the one cycle following each event edge, low otherwise.
REQ-023 Two events SHALL NOT occur on consecutive edges, because a new edge needs match_q=0 first; LEDR[0] therefore never stays high for 2 cycles.
REQ-024 HEX0/HEX1 SHALL be combinational decodes of the registered digits; digits 0-9 use the standard 7-segment patterns.
REQ-025 A digit value above 9 is unreachable; if present, its HEX output SHALL be blank (all segments off).
REQ-026 With SEG_ACTIVE_LOW=1, digit 0 SHALL drive 1000000, 1 drives 1111001, 8 drives 0000000.

Reset
REQ-027 On an edge with SW[1]=1: count <- 00, LEDR[0] <- 0, LEDR[1] <- 0, and match_q <- SW[2].
REQ-028 Because match_q loads SW[2] on reset, a match held high through reset SHALL NOT be counted after reset.
REQ-029 Reset SHALL take priority over a simultaneous event; that event is discarded.
REQ-030 Power-up state before the first reset is undefined; the bench SHALL apply reset first.

Verification
REQ-031 Reset, then SW[3]=1 and three separate 1-cycle SW[2] pulses -> HEX1/HEX0 show 03, three one-cycle LEDR[0] pulses, LEDR[1]=0.
REQ-032 Hold SW[2] high for 10 cycles with SW[3]=1 -> count +1 only, exactly one LEDR[0] pulse.
REQ-033 Raise SW[2] while SW[3]=0, then raise SW[3] while SW[2] stays high -> count unchanged, no LEDR[0] pulse.
REQ-034 Drive 100 events with SW[4]=0 -> after event 100 count = 00 and LEDR[1]=1; repeat with SW[4]=1 -> count = 99 and LEDR[1]=1.
REQ-035 Count at 09 + event -> 10 (ones carry); count at 42 with SW[1]=1 and an SW[2] rising edge on the same edge -> 00, LEDR=00, no count afterwards.
REQ-036 Hold SW[2] high through reset -> count stays 00 after release until SW[2] falls and rises again.

Source files
------------

// File: rtl/detect_event_counter.sv
// Counts rising edges of an upstream match level as a two-digit BCD value
// and shows it on two 7-segment displays, with event pulse and sticky limit flag.
module detect_event_counter #(
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic [4:0] SW,
  output logic [1:0] LEDR,
  output logic [6:0] HEX0,
  output logic [6:0] HEX1
);

  logic clk;
  logic rst;
  logic match_in;
  logic count_en;
  logic sat_mode;

  assign clk      = SW[0];
  assign rst      = SW[1];
  assign match_in = SW[2];
  assign count_en = SW[3];
  assign sat_mode = SW[4];

  logic       match_q;
  logic [3:0] ones_q, ones_d;
  logic [3:0] tens_q, tens_d;
  logic       pulse_q, pulse_d;
  logic       limit_q, limit_d;
  logic       event_w;

  // match_q follows the input even while disabled, so a level that rose
  // during a disabled window is never seen as a fresh edge later.
  assign event_w = match_in & ~match_q & count_en;

  always_comb begin
    ones_d  = ones_q;
    tens_d  = tens_q;
    limit_d = limit_q;
    pulse_d = event_w;
    if (event_w) begin
      if (tens_q == 4'd9 && ones_q == 4'd9) begin
        limit_d = 1'b1;
        if (!sat_mode) begin
          ones_d = 4'd0;
          tens_d = 4'd0;
        end
      end else if (ones_q == 4'd9) begin
        ones_d = 4'd0;
        tens_d = tens_q + 4'd1;
      end else begin
        ones_d = ones_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      match_q <= match_in;
      ones_q  <= 4'd0;
      tens_q  <= 4'd0;
      pulse_q <= 1'b0;
      limit_q <= 1'b0;
    end else begin
      match_q <= match_in;
      ones_q  <= ones_d;
      tens_q  <= tens_d;
      pulse_q <= pulse_d;
      limit_q <= limit_d;
    end
  end

  // Lit-segment pattern in gfedcba order; non-decimal digits blank.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] p;
    case (d)
      4'd0:    p = 7'b0111111;
      4'd1:    p = 7'b0000110;
      4'd2:    p = 7'b1011011;
      4'd3:    p = 7'b1001111;
      4'd4:    p = 7'b1100110;
      4'd5:    p = 7'b1101101;
      4'd6:    p = 7'b1111101;
      4'd7:    p = 7'b0000111;
      4'd8:    p = 7'b1111111;
      4'd9:    p = 7'b1101111;
      default: p = 7'b0000000;
    endcase
    return SEG_ACTIVE_LOW ? ~p : p;
  endfunction

  assign HEX0 = seg7(ones_q);
  assign HEX1 = seg7(tens_q);
  assign LEDR = {limit_q, pulse_q};

endmodule

// File: tb/tb_detect_event_counter.sv
// Bench for detect_event_counter: directed scenarios plus random traffic,
// compared every cycle against an integer-count reference model.
module tb_detect_event_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       m   = 1'b0;
  logic       en  = 1'b0;
  logic       lim = 1'b0;
  logic [1:0] ledr;
  logic [6:0] hex0;
  logic [6:0] hex1;

  detect_event_counter #(.SEG_ACTIVE_LOW(1'b1)) dut (
    .SW   ({lim, en, m, rst, clk}),
    .LEDR (ledr),
    .HEX0 (hex0),
    .HEX1 (hex1)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  // Reference model state
  int   exp_cnt    = 0;
  bit   exp_pulse  = 1'b0;
  bit   exp_sticky = 1'b0;
  bit   prev_m     = 1'b0;
  logic [6:0] seg_tab [10];

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [13:0] exp_hex(input int c);
    return {seg_tab[c / 10], seg_tab[c % 10]};
  endfunction

  task automatic model_edge();
    bit ev;
    if (rst) begin
      exp_cnt    = 0;
      exp_pulse  = 1'b0;
      exp_sticky = 1'b0;
    end else begin
      ev = m && !prev_m && en;
      exp_pulse = ev;
      if (ev) begin
        if (exp_cnt == 99) begin
          exp_sticky = 1'b1;
          if (!lim) exp_cnt = 0;
        end else begin
          exp_cnt = exp_cnt + 1;
        end
      end
    end
    prev_m = m;
  endtask

  // Driver: apply inputs mid-cycle, advance one edge, check outputs after it.
  task automatic cycle(input logic r, input logic mi, input logic e, input logic l);
    @(negedge clk);
    rst = r; m = mi; en = e; lim = l;
    @(posedge clk);
    model_edge();
    #1;
    check("ledr", {30'd0, ledr}, {30'd0, exp_sticky, exp_pulse});
    check("hex", {18'd0, hex1, hex0}, {18'd0, exp_hex(exp_cnt)});
  endtask

  task automatic one_event(input logic l);
    cycle(1'b0, 1'b1, 1'b1, l);
    cycle(1'b0, 1'b0, 1'b1, l);
  endtask

  task automatic expect_count(input string tag, input int c, input logic [1:0] leds);
    logic [13:0] h;
    h = {seg_tab[c / 10], seg_tab[c % 10]};
    check(tag, {18'd0, hex1, hex0}, {18'd0, h});
    check({tag, "_led"}, {30'd0, ledr}, {30'd0, leds});
  endtask

  initial begin
    seg_tab[0] = 7'b1000000; seg_tab[1] = 7'b1111001;
    seg_tab[2] = 7'b0100100; seg_tab[3] = 7'b0110000;
    seg_tab[4] = 7'b0011001; seg_tab[5] = 7'b0010010;
    seg_tab[6] = 7'b0000010; seg_tab[7] = 7'b1111000;
    seg_tab[8] = 7'b0000000; seg_tab[9] = 7'b0010000;

    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    expect_count("reset", 0, 2'b00);

    // Three short pulses
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b1, 1'b1, 1'b0);
      cycle(1'b0, 1'b0, 1'b1, 1'b0);
      cycle(1'b0, 1'b0, 1'b1, 1'b0);
    end
    expect_count("three_pulses", 3, 2'b00);

    // Long level counts once
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    expect_count("long_level", 4, 2'b00);

    // Edge while disabled, then enable with level still high
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    expect_count("disabled_edge", 4, 2'b00);

    // Ones carry, then reset colliding with an edge at 42
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) one_event(1'b0);
    expect_count("count09", 9, 2'b00);
    one_event(1'b0);
    expect_count("carry10", 10, 2'b00);
    for (int i = 0; i < 32; i++) one_event(1'b0);
    expect_count("count42", 42, 2'b00);
    cycle(1'b1, 1'b1, 1'b1, 1'b0);
    expect_count("rst_vs_event", 0, 2'b00);
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 1'b1, 1'b0);
    expect_count("held_through_rst", 0, 2'b00);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, 1'b1, 1'b0);
    expect_count("fresh_edge_pulse", 1, 2'b01);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    expect_count("pulse_one_cycle", 1, 2'b00);

    // Wrap mode: 100 events
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 100; i++) one_event(1'b0);
    expect_count("wrap100", 0, 2'b10);
    one_event(1'b0);
    expect_count("wrap_sticky", 1, 2'b10);

    // Saturate mode: 100 events, then one more
    cycle(1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 100; i++) one_event(1'b1);
    expect_count("sat100", 99, 2'b10);
    one_event(1'b1);
    expect_count("sat_hold", 99, 2'b10);
    // Mode change applies on the next event only
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    expect_count("mode_change", 99, 2'b10);
    one_event(1'b0);
    expect_count("wrap_after_sat", 0, 2'b10);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 63) == 0), $urandom_range(0, 1),
            ($urandom_range(0, 7) != 0), ($urandom_range(0, 15) == 0) ? ~lim : lim);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
